// File: rtl/tcam_pkg.sv
// Shared TCAM definitions: default geometry, rule entry layout and the lowest-index priority encoder.
package tcam_pkg;

  localparam int TCAM_NUM_RULES   = 64;
  localparam int TCAM_KEY_LEN     = 32;
  localparam int TCAM_MAX_KEY_LEN = 128;
  localparam int TCAM_MAX_RULES   = 1024;
  localparam int TCAM_MAX_IDX_W   = $clog2(TCAM_MAX_RULES);

  // Fields are sized for the widest supported key; narrower arrays zero-extend, which never alters a match.
  typedef struct packed {
    logic                        valid;
    logic [TCAM_MAX_KEY_LEN-1:0] value;
    logic [TCAM_MAX_KEY_LEN-1:0] mask;
  } tcam_entry_t;

  function automatic logic [TCAM_MAX_IDX_W-1:0] lowest_set_idx(input logic [TCAM_MAX_RULES-1:0] vec);
    logic [TCAM_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = TCAM_MAX_RULES - 1; i >= 0; i--) begin
      if (vec[i]) idx = TCAM_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcam_ternary_cell.sv
// One TCAM rule entry: value/mask/valid storage plus a registered ternary match bit.
module tcam_ternary_cell
  import tcam_pkg::*;
#(
  parameter int KEY_LEN = TCAM_KEY_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [KEY_LEN-1:0] wr_value_i,
  input  logic [KEY_LEN-1:0] wr_mask_i,
  input  logic               wr_valid_i,
  input  logic [KEY_LEN-1:0] search_key_i,
  output logic               match_o
);

  tcam_entry_t                 entry_q, entry_d;
  logic                        match_q, match_d;
  logic [TCAM_MAX_KEY_LEN-1:0] key_ext;

  assign key_ext = TCAM_MAX_KEY_LEN'(search_key_i);

  // The match is taken from the current contents, so a same-cycle write only affects later searches.
  always_comb begin
    entry_d = entry_q;
    if (wr_en_i) begin
      entry_d.valid = wr_valid_i;
      entry_d.value = TCAM_MAX_KEY_LEN'(wr_value_i);
      entry_d.mask  = TCAM_MAX_KEY_LEN'(wr_mask_i);
    end
    match_d = entry_q.valid && (((key_ext ^ entry_q.value) & ~entry_q.mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q.valid <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      entry_q <= entry_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/tcam_ternary_array.sv
// Ternary match array with registered lowest-index priority encode (2-cycle search latency).
// Optional TCAM_MULTI_HIT_EN adds result_multi (more than one rule matched); otherwise it is tied low.
module tcam_ternary_array
  import tcam_pkg::*;
#(
  parameter  int NUM_RULES = TCAM_NUM_RULES,
  parameter  int KEY_LEN   = TCAM_KEY_LEN,
  localparam int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [KEY_LEN-1:0] wr_value,
  input  logic [KEY_LEN-1:0] wr_mask,
  input  logic               wr_valid,
  input  logic               search_valid,
  input  logic [KEY_LEN-1:0] search_key,
  output logic               result_valid,
  output logic               result_hit,
  output logic [IDX_W-1:0]   result_idx,
  output logic               result_multi
);

  logic [NUM_RULES-1:0] mv;
  logic                 s1_valid_q;
  logic                 result_valid_q, result_valid_d;
  logic                 result_hit_q, result_hit_d;
  logic [IDX_W-1:0]     result_idx_q, result_idx_d;

  for (genvar i = 0; i < NUM_RULES; i++) begin : g_cell
    tcam_ternary_cell #(
      .KEY_LEN(KEY_LEN)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (wr_en && (wr_addr == IDX_W'(i))),
      .wr_value_i  (wr_value),
      .wr_mask_i   (wr_mask),
      .wr_valid_i  (wr_valid),
      .search_key_i(search_key),
      .match_o     (mv[i])
    );
  end

  // Result fields only move when a search lands, so they hold between results.
  always_comb begin
    result_valid_d = s1_valid_q;
    result_hit_d   = result_hit_q;
    result_idx_d   = result_idx_q;
    if (s1_valid_q) begin
      result_hit_d = |mv;
      result_idx_d = IDX_W'(lowest_set_idx(TCAM_MAX_RULES'(mv)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      result_idx_q   <= '0;
    end else begin
      s1_valid_q     <= search_valid;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      result_idx_q   <= result_idx_d;
    end
  end

`ifdef TCAM_MULTI_HIT_EN
  logic result_multi_q, result_multi_d;

  // Clearing the lowest set bit leaves something behind exactly when two or more rules matched.
  always_comb begin
    result_multi_d = result_multi_q;
    if (s1_valid_q) result_multi_d = |(mv & (mv - NUM_RULES'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) result_multi_q <= 1'b0;
    else     result_multi_q <= result_multi_d;
  end

  assign result_multi = result_multi_q;
`else
  assign result_multi = 1'b0;
`endif

  assign result_valid = result_valid_q;
  assign result_hit   = result_hit_q;
  assign result_idx   = result_idx_q;

endmodule
